bdc_command_sequencer: RTL

BDC_COMMAND_SEQUENCER -- requirements
Module: bdc_command_sequencer

---
 rtl/bdc_command_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/bdc_command_sequencer.sv
// bdc_command_sequencer: turns one BDC command into a byte sequence on the byte engine
//   clk, rst          : single clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake, ready only while idle
//   cmd_opcode/addr/wdata, cmd_has_addr, cmd_wr_bytes, cmd_rd_bytes, cmd_delay : command fields
//   rsp_valid/rsp_data: one-cycle completion pulse and read result (held until next command)
//   tgt_clk_pulse     : target-clock tick, counted only during the post-write delay
//   bdc_data_in, bdc_send_data, bdc_read_data, bdc_data_out, bdc_ready : byte engine side
module bdc_command_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_opcode,
   input  logic [15:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   input  logic        cmd_has_addr,
   input  logic [1:0]  cmd_wr_bytes,
   input  logic [1:0]  cmd_rd_bytes,
   input  logic        cmd_delay,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   input  logic        tgt_clk_pulse,
   output logic [7:0]  bdc_data_in,
   output logic        bdc_send_data,
   output logic        bdc_read_data,
   input  logic [7:0]  bdc_data_out,
   input  logic        bdc_ready
);
   typedef enum logic [2:0] {IDLE, TX_ISSUE, TX_WAIT, DELAY, RX_ISSUE, RX_WAIT, RESP} state_t;
   state_t      state, state_n;
   logic [39:0] tx_sr;
   logic [2:0]  tx_left;
   logic [1:0]  rd_left;
   logic        dly;
   logic [4:0]  dcnt;
   logic [1:0]  wr_n, rd_n;
   logic [15:0] w_just;
   logic        accept, tx_done, rx_done, send_n, read_n;
   logic [7:0]  data_in_n;
   logic [15:0] rsp_data_n;

   assign wr_n   = cmd_wr_bytes == 2'd3 ? 2'd2 : cmd_wr_bytes;
   assign rd_n   = cmd_rd_bytes == 2'd3 ? 2'd2 : cmd_rd_bytes;
   assign w_just = wr_n == 2'd2 ? cmd_wdata : wr_n == 2'd1 ? {cmd_wdata[7:0], 8'h00} : 16'h0000;
   assign accept = state == IDLE && cmd_valid;
   // in the strobe cycle the engine has not yet seen the request, so its ready is stale
   assign tx_done = state == TX_WAIT && bdc_ready && !bdc_send_data;
   assign rx_done = state == RX_WAIT && bdc_ready && !bdc_read_data;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (cmd_valid) state_n = TX_ISSUE;
         TX_ISSUE: if (bdc_ready) state_n = TX_WAIT;
         TX_WAIT:  if (tx_done) state_n = tx_left > 3'd1 ? TX_ISSUE : dly ? DELAY : rd_left != 2'd0 ? RX_ISSUE : RESP;
         DELAY:    if (tgt_clk_pulse && dcnt == 5'd15) state_n = rd_left != 2'd0 ? RX_ISSUE : RESP;
         RX_ISSUE: if (bdc_ready) state_n = RX_WAIT;
         RX_WAIT:  if (rx_done) state_n = rd_left > 2'd1 ? RX_ISSUE : RESP;
         RESP:     state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   always_comb begin
      send_n     = state == TX_ISSUE && bdc_ready;
      read_n     = state == RX_ISSUE && bdc_ready;
      data_in_n  = send_n ? tx_sr[39:32] : bdc_data_in;
      rsp_data_n = accept ? 16'h0000 : rx_done ? {rsp_data[7:0], bdc_data_out} : rsp_data;
   end

   // outputs are registered from the next state so they line up with the state they belong to
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_data      <= 16'h0000;
         bdc_send_data <= 1'b0;
         bdc_read_data <= 1'b0;
         bdc_data_in   <= 8'h00;
         dcnt          <= 5'd0;
         tx_sr         <= 40'h0;
         tx_left       <= 3'd0;
         rd_left       <= 2'd0;
         dly           <= 1'b0;
      end else begin
         cmd_ready     <= state_n == IDLE;
         rsp_valid     <= state_n == RESP;
         rsp_data      <= rsp_data_n;
         bdc_send_data <= send_n;
         bdc_read_data <= read_n;
         bdc_data_in   <= data_in_n;
         dcnt          <= state == DELAY ? dcnt + {4'h0, tgt_clk_pulse} : 5'd0;
         if (accept) begin
            // bytes are packed left-justified so the next one is always tx_sr[39:32]
            tx_sr   <= cmd_has_addr ? {cmd_opcode, cmd_addr, w_just} : {cmd_opcode, w_just, 16'h0000};
            tx_left <= 3'd1 + (cmd_has_addr ? 3'd2 : 3'd0) + {1'b0, wr_n};
            rd_left <= rd_n;
            dly     <= cmd_delay;
         end
         if (tx_done) begin
            tx_sr   <= {tx_sr[31:0], 8'h00};
            tx_left <= tx_left - 3'd1;
         end
         if (rx_done)
            rd_left <= rd_left - 2'd1;
      end
   end
endmodule
